// File: rtl/dsp_stage_pkg.sv
// Shared widths, operand-set record and buffer-state encoding for the DSP operand stager.
package dsp_stage_pkg;

   localparam int A_W_DEF   = 17;
   localparam int EXT_W_DEF = 34;
   localparam int C_W_DEF   = 32;
   localparam int CNT_W_DEF = 16;

   typedef struct packed {
      logic [A_W_DEF-1:0] a;
      logic [A_W_DEF-1:0] b;
      logic [C_W_DEF-1:0] c;
   } operand_set_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/dsp_operand_stager_if.sv
// Upstream/downstream bundle of the DSP operand stager; master drives operands, slave is the stager.
interface dsp_operand_stager_if
   import dsp_stage_pkg::*;
#(
   parameter int EXT_W = EXT_W_DEF,
   parameter int C_W   = C_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) ();

   // Valid/ready: a transfer happens on a rising edge where valid & ready are both 1;
   // a source holding valid keeps its data stable until that edge, ready may not depend on valid.
   logic             in_valid;
   logic             in_ready;
   logic [EXT_W-1:0] in_a;
   logic [EXT_W-1:0] in_b;
   logic [C_W-1:0]   in_c;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [EXT_W-1:0] out_a;
   logic [EXT_W-1:0] out_b;
   logic [C_W-1:0]   out_c;
   logic [CNT_W-1:0] accept_cnt;
   logic             range_err;
   buf_state_t       buf_state;

   modport master (
      output in_valid, in_a, in_b, in_c, flush, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_c, accept_cnt, range_err, buf_state
   );

   modport slave (
      input  in_valid, in_a, in_b, in_c, flush, out_ready,
      output in_ready, out_valid, out_a, out_b, out_c, accept_cnt, range_err, buf_state
   );

endinterface

// File: rtl/dsp_operand_stager_skid_buffer2.sv
// Generic 2-entry valid/ready buffer: head register feeds the output, skid register absorbs one extra beat.
module skid_buffer2
   import dsp_stage_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o,
   output buf_state_t   state_o
);

   buf_state_t   state_q;
   logic         in_ready_q;
   logic         out_valid_q;
   logic [W-1:0] head_q;
   logic [W-1:0] skid_q;
   logic         push;
   logic         pop;

   assign push = in_valid_i & in_ready_q;
   assign pop  = out_valid_q & out_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BUF_EMPTY;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         head_q      <= '0;
         skid_q      <= '0;
      end else if (flush_i) begin
         state_q     <= BUF_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            BUF_EMPTY: begin
               in_ready_q <= 1'b1;
               if (push) begin
                  head_q      <= in_data_i;
                  out_valid_q <= 1'b1;
                  state_q     <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (push && pop) begin
                  head_q <= in_data_i;
               end else if (push) begin
                  skid_q     <= in_data_i;
                  in_ready_q <= 1'b0;
                  state_q    <= BUF_FULL;
               end else if (pop) begin
                  out_valid_q <= 1'b0;
                  state_q     <= BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               // in_ready is low here, so a pop is the only way out
               if (pop) begin
                  head_q     <= skid_q;
                  in_ready_q <= 1'b1;
                  state_q    <= BUF_ONE;
               end
            end
            default: begin
               state_q     <= BUF_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = head_q;
   assign state_o     = state_q;

endmodule

// File: rtl/dsp_operand_stager.sv
// Stages {a,b,c} for the multiply-shift-add stage: narrows a/b to A_W bits, counts accepts.
// Build option DSP_STAGER_RANGE_CHECK_EN: clamp out-of-range a/b and raise sticky range_err.
module dsp_operand_stager
   import dsp_stage_pkg::*;
#(
   parameter int A_W   = A_W_DEF,
   parameter int EXT_W = EXT_W_DEF,
   parameter int C_W   = C_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic                  clk,
   input logic                  rst_n,
   dsp_operand_stager_if.slave  bus
);

   localparam int               DW      = 2 * A_W + C_W;
   localparam logic [A_W-1:0]   A_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [A_W-1:0]   fmt_a;
   logic [A_W-1:0]   fmt_b;
   logic             a_over;
   logic             b_over;
   logic             in_ready_w;
   logic             push;
   logic [DW-1:0]    buf_in;
   logic [DW-1:0]    buf_out;
   logic [CNT_W-1:0] accept_cnt_q;

   assign push   = bus.in_valid & in_ready_w;
   assign a_over = |bus.in_a[EXT_W-1:A_W];
   assign b_over = |bus.in_b[EXT_W-1:A_W];

`ifdef DSP_STAGER_RANGE_CHECK_EN
   logic range_err_q;

   assign fmt_a = a_over ? A_MAX : bus.in_a[A_W-1:0];
   assign fmt_b = b_over ? A_MAX : bus.in_b[A_W-1:0];

   // Sticky until reset; flush does not clear it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         range_err_q <= 1'b0;
      end else if (push && (a_over || b_over)) begin
         range_err_q <= 1'b1;
      end
   end

   assign bus.range_err = range_err_q;
`else
   logic unused_over;

   assign fmt_a         = bus.in_a[A_W-1:0];
   assign fmt_b         = bus.in_b[A_W-1:0];
   assign unused_over   = a_over | b_over;
   assign bus.range_err = 1'b0;
`endif

   assign buf_in = {fmt_a, fmt_b, bus.in_c};

   skid_buffer2 #(
      .W (DW)
   ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (bus.flush),
      .in_valid_i  (bus.in_valid),
      .in_ready_o  (in_ready_w),
      .in_data_i   (buf_in),
      .out_valid_o (bus.out_valid),
      .out_ready_i (bus.out_ready),
      .out_data_o  (buf_out),
      .state_o     (bus.buf_state)
   );

   // A handshake in a flush cycle still counts even though its data is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accept_cnt_q <= '0;
      end else if (push) begin
         accept_cnt_q <= accept_cnt_q + CNT_ONE;
      end
   end

   assign bus.in_ready   = in_ready_w;
   assign bus.out_a      = {{(EXT_W-A_W){1'b0}}, buf_out[DW-1 -: A_W]};
   assign bus.out_b      = {{(EXT_W-A_W){1'b0}}, buf_out[C_W +: A_W]};
   assign bus.out_c      = buf_out[C_W-1:0];
   assign bus.accept_cnt = accept_cnt_q;

endmodule

// File: tb/tb_dsp_operand_stager.sv
// Directed bench for dsp_operand_stager: single-beat vector table plus backpressure, streaming,
// flush, counter-wrap and mid-stream reset sequences.
module tb_dsp_operand_stager;
   import dsp_stage_pkg::*;

   localparam int OW = 2 * EXT_W_DEF + C_W_DEF;

   typedef struct {
      logic [33:0] a;
      logic [33:0] b;
      logic [31:0] c;
      logic [33:0] ea;
      logic [33:0] eb;
      logic [31:0] ec;
      logic        ee;
   } vec_t;

   logic clk;
   logic rst_n;

   dsp_operand_stager_if bus ();

   dsp_operand_stager dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int            n_chk  = 0;
   int            n_bad  = 0;
   int            n_pops = 0;
   logic          mon_en = 1'b0;
   logic [15:0]   exp_cnt;
   logic [OW-1:0] exp_q[$];
   vec_t          vecs[6];

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within time budget");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [OW-1:0] pack_exp(input operand_set_t s);
      return {17'd0, s.a, 17'd0, s.b, s.c};
   endfunction

   task automatic drive(input logic [33:0] a, input logic [33:0] b, input logic [31:0] c);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_c     = c;
   endtask

   task automatic drive_q(input logic [16:0] a, input logic [16:0] b, input logic [31:0] c);
      operand_set_t s;
      s.a = a;
      s.b = b;
      s.c = c;
      exp_q.push_back(pack_exp(s));
      drive({17'd0, a}, {17'd0, b}, c);
   endtask

   // ---------------- scoreboard: checks every output handshake ----------------
   always @(negedge clk) begin
      if (mon_en && rst_n && bus.out_valid && bus.out_ready) begin
         n_pops++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL pop_unexpected: got %0h, expected no transfer", {bus.out_a, bus.out_b, bus.out_c});
         end else begin
            chk("pop_order", {bus.out_a, bus.out_b, bus.out_c}, exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int pops0;

`ifdef DSP_STAGER_RANGE_CHECK_EN
      vecs[0] = '{34'd5,            34'd7,      32'd100,        34'd5,      34'd7,      32'd100,        1'b0};
      vecs[1] = '{34'd131071,       34'd0,      32'hFFFF_FFFF,  34'd131071, 34'd0,      32'hFFFF_FFFF,  1'b0};
      vecs[2] = '{34'd131072,       34'd3,      32'd0,          34'd131071, 34'd3,      32'd0,          1'b1};
      vecs[3] = '{34'h3_FFFF_FFFF,  34'd131073, 32'h1234_5678,  34'd131071, 34'd131071, 32'h1234_5678,  1'b1};
      vecs[4] = '{34'd0,            34'd0,      32'd0,          34'd0,      34'd0,      32'd0,          1'b1};
      vecs[5] = '{34'd12345,        34'd99999,  32'hDEAD_BEEF,  34'd12345,  34'd99999,  32'hDEAD_BEEF,  1'b1};
`else
      vecs[0] = '{34'd5,            34'd7,      32'd100,        34'd5,      34'd7,      32'd100,        1'b0};
      vecs[1] = '{34'd131071,       34'd0,      32'hFFFF_FFFF,  34'd131071, 34'd0,      32'hFFFF_FFFF,  1'b0};
      vecs[2] = '{34'd131072,       34'd3,      32'd0,          34'd0,      34'd3,      32'd0,          1'b0};
      vecs[3] = '{34'h3_FFFF_FFFF,  34'd131073, 32'h1234_5678,  34'd131071, 34'd1,      32'h1234_5678,  1'b0};
      vecs[4] = '{34'd0,            34'd0,      32'd0,          34'd0,      34'd0,      32'd0,          1'b0};
      vecs[5] = '{34'd12345,        34'd99999,  32'hDEAD_BEEF,  34'd12345,  34'd99999,  32'hDEAD_BEEF,  1'b0};
`endif

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_c      = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      exp_cnt       = '0;

      // reset values while reset is held
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_in_ready",   bus.in_ready,   0);
      chk("rst_out_valid",  bus.out_valid,  0);
      chk("rst_accept_cnt", bus.accept_cnt, 0);
      chk("rst_range_err",  bus.range_err,  0);
      chk("rst_out_a",      bus.out_a,      0);
      chk("rst_out_c",      bus.out_c,      0);
      tick;
      chk("rst_hold_in_ready", bus.in_ready, 0);
      rst_n = 1'b1;
      tick;
      chk("rst_release_in_ready", bus.in_ready, 1);
      chk("rst_release_state",    bus.buf_state, BUF_EMPTY);

      // single-beat vectors into an empty buffer, downstream always ready
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].c);
         tick;
         bus.in_valid = 1'b0;
         exp_cnt++;
         chk($sformatf("vec%0d_out_valid", i), bus.out_valid,  1);
         chk($sformatf("vec%0d_out_a", i),     bus.out_a,      vecs[i].ea);
         chk($sformatf("vec%0d_out_b", i),     bus.out_b,      vecs[i].eb);
         chk($sformatf("vec%0d_out_c", i),     bus.out_c,      vecs[i].ec);
         chk($sformatf("vec%0d_accept", i),    bus.accept_cnt, exp_cnt);
         chk($sformatf("vec%0d_range_err", i), bus.range_err,  vecs[i].ee);
         tick;
         chk($sformatf("vec%0d_drained", i),   bus.out_valid,  0);
      end

      // backpressure: two accepted, third held until downstream frees a slot
      mon_en        = 1'b1;
      pops0         = n_pops;
      bus.out_ready = 1'b0;
      drive_q(17'd11, 17'd21, 32'd31);
      tick;
      exp_cnt++;
      drive_q(17'd12, 17'd22, 32'd32);
      tick;
      exp_cnt++;
      chk("bp_in_ready_full", bus.in_ready,  0);
      chk("bp_state_full",    bus.buf_state, BUF_FULL);
      chk("bp_accept",        bus.accept_cnt, exp_cnt);
      drive_q(17'd13, 17'd23, 32'd33);
      tick;
      chk("bp_hold_a",        bus.out_a,     34'd11);
      chk("bp_hold_c",        bus.out_c,     32'd31);
      chk("bp_third_blocked", bus.accept_cnt, exp_cnt);
      bus.out_ready = 1'b1;
      tick;
      chk("bp_second_a",      bus.out_a,     34'd12);
      chk("bp_ready_again",   bus.in_ready,  1);
      tick;
      exp_cnt++;
      bus.in_valid = 1'b0;
      chk("bp_third_a",       bus.out_a,     34'd13);
      tick;
      chk("bp_drained",       bus.out_valid, 0);
      chk("bp_accept_end",    bus.accept_cnt, exp_cnt);
      chk("bp_pop_count",     n_pops - pops0, 3);

      // streaming in ONE: simultaneous push and pop for 10 cycles
      pops0         = n_pops;
      bus.out_ready = 1'b0;
      drive_q(17'd0, 17'd1000, 32'hC0DE_0000);
      tick;
      exp_cnt++;
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         drive_q(17'(i * 3), 17'(1000 + i), 32'hC0DE_0000 + 32'(i));
         tick;
         exp_cnt++;
         chk($sformatf("stream%0d_state", i),    bus.buf_state, BUF_ONE);
         chk($sformatf("stream%0d_in_ready", i), bus.in_ready,  1);
      end
      bus.in_valid = 1'b0;
      tick;
      chk("stream_drained",    bus.out_valid,  0);
      chk("stream_pop_count",  n_pops - pops0, 11);
      chk("stream_accept",     bus.accept_cnt, exp_cnt);
      mon_en = 1'b0;

      // flush while FULL with in_valid high: nothing accepted, buffer emptied
      bus.out_ready = 1'b0;
      drive(34'd41, 34'd51, 32'd61);
      tick;
      exp_cnt++;
      drive(34'd42, 34'd52, 32'd62);
      tick;
      exp_cnt++;
      chk("flush_pre_state", bus.buf_state, BUF_FULL);
      drive(34'd43, 34'd53, 32'd63);
      bus.flush = 1'b1;
      tick;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_full_out_valid", bus.out_valid,  0);
      chk("flush_full_accept",    bus.accept_cnt, exp_cnt);
      chk("flush_full_state",     bus.buf_state,  BUF_EMPTY);
      chk("flush_full_in_ready",  bus.in_ready,   1);

      // flush in ONE with a push: handshake counted, entry dropped
      drive(34'd44, 34'd54, 32'd64);
      tick;
      exp_cnt++;
      drive(34'd45, 34'd55, 32'd65);
      bus.flush = 1'b1;
      tick;
      exp_cnt++;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_one_out_valid", bus.out_valid,  0);
      chk("flush_one_accept",    bus.accept_cnt, exp_cnt);
      tick;
      chk("flush_one_not_kept",  bus.out_valid,  0);

      // accept counter wrap at 2^16
      bus.out_ready = 1'b1;
      drive(34'd0, 34'd0, 32'd0);
      while (exp_cnt != 16'hFFFF) begin
         tick;
         exp_cnt++;
      end
      chk("wrap_max",  bus.accept_cnt, 16'hFFFF);
      tick;
      exp_cnt++;
      chk("wrap_zero", bus.accept_cnt, 16'h0000);
      bus.in_valid = 1'b0;
      tick;
      chk("wrap_drained", bus.out_valid, 0);

      // asynchronous reset in the middle of a FULL buffer
      bus.out_ready = 1'b0;
      drive(34'd71, 34'd81, 32'd91);
      tick;
      drive(34'd72, 34'd82, 32'd92);
      tick;
      bus.in_valid = 1'b0;
      chk("ares_pre_valid", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ares_out_valid",  bus.out_valid,  0);
      chk("ares_accept_cnt", bus.accept_cnt, 0);
      chk("ares_in_ready",   bus.in_ready,   0);
      chk("ares_range_err",  bus.range_err,  0);
      chk("ares_out_b",      bus.out_b,      0);
      tick;
      rst_n = 1'b1;
      tick;
      exp_cnt = '0;
      chk("ares_rel_in_ready",  bus.in_ready,  1);
      chk("ares_rel_out_valid", bus.out_valid, 0);
      chk("ares_rel_state",     bus.buf_state, BUF_EMPTY);

      // first beat after reset comes through alone
      mon_en        = 1'b1;
      pops0         = n_pops;
      bus.out_ready = 1'b1;
      drive_q(17'd99, 17'd98, 32'd97);
      tick;
      exp_cnt++;
      bus.in_valid = 1'b0;
      chk("post_out_valid", bus.out_valid,  1);
      chk("post_accept",    bus.accept_cnt, exp_cnt);
      tick;
      chk("post_drained",   bus.out_valid,  0);
      chk("post_pop_count", n_pops - pops0, 1);
      chk("scoreboard_empty", exp_q.size(), 0);
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule
